seq_feed_ctrl: RTL and testbench
================================

// Module: seq_feed_ctrl
// PURPOSE
//  Sequencer for the bit-serial sequence-detector FSM. Accepts a parallel word on a start
//  strobe, clears the detector, then feeds the word one bit per clock (LSB first) on the
//  detector's value input. Captures the detector's out bit for every fed bit into a match
//  vector and a match count, then pulses done. Sits between the register/bus side and the detector.
// PARAMETERS
//  WIDTH   16                   bits per word fed to the detector
//  CNT_W   $clog2(WIDTH+1) (5)  width of match_cnt; must hold WIDTH without wrap
// PORTS
//  clock      in   1      single clock, all state on rising edge
//  reset      in   1      asynchronous, active-low; 0 forces reset state immediately
//  start      in   1      request; sampled only in IDLE
//  data_in    in   WIDTH  word to feed; latched on accepted start
//  busy       out  1      1 from the cycle after accept through the last SHIFT cycle
//  done       out  1      1-cycle pulse after last bit captured
//  det_clr    out  1      1-cycle active-high clear to detector, before first bit
//  det_value  out  1      bit presented to detector value input
//  det_out    in   1      detector output for currently presented bit (Mealy, same cycle)
//  match_vec  out  WIDTH  det_out captured per bit; bit i <-> data_in[i]
//  match_cnt  out  CNT_W  number of 1s captured in match_vec
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE; busy=done=det_clr=det_value=0; match_vec=0; match_cnt=0;
//   shift reg and bit index = 0. Mid-operation reset aborts the word; no done is issued.
//  FSM states: IDLE -> CLEAR -> SHIFT -> DONE -> IDLE.
//   IDLE : start=1 at edge k -> latch data_in, clear match_vec/match_cnt/idx, go CLEAR.
//   CLEAR: one cycle (k+1); det_clr=1, busy=1, det_value=0. -> SHIFT.
//   SHIFT: WIDTH cycles (k+2 .. k+1+WIDTH); det_value=shreg[0]; each edge: match_vec[idx]<=det_out,
//          match_cnt += det_out, shreg >>= 1, idx++. After idx==WIDTH-1 captured -> DONE.
//   DONE : one cycle (k+2+WIDTH); done=1, busy=0, det_value=0. -> IDLE unconditionally.
//  Latency: accepted start to done pulse = WIDTH+2 cycles (18 at default).
//  start outside IDLE ignored (incl. DONE cycle); start held high -> back-to-back words
//   separated by exactly one IDLE cycle. data_in changes after accept have no effect.
//  det_value is 0 in every non-SHIFT state. det_out is ignored outside SHIFT.
//  match_vec/match_cnt hold final values from DONE until the next accepted start.
//  match_cnt: unsigned, CNT_W bits, max WIDTH; no saturation logic needed (cannot wrap).
//  All outputs registered except det_value (= shreg[0] gated by state==SHIFT).
// STRUCTURE
//  Shared package seq_feed_pkg: state encoding (IDLE=2'd0, CLEAR=2'd1, SHIFT=2'd2,
//   DONE=2'd3), default WIDTH, CNT_W derivation function.
//  One sub-module: seq_piso_reg (WIDTH-bit load/shift-right register, async active-low reset,
//   ports: clock, reset, load, shift, d, q0). FSM, index counter, capture logic stay in top.
// TESTING (bench instantiates a stub detector; pass-through stub: det_out = det_value)
//  1. reset=0 at t=0 with start=1 -> all outputs 0, state IDLE; release, no start -> stays idle.
//  2. Pass-through, data_in=16'b0101101101110010 -> det_clr one cycle, det_value stream LSB-first
//     = 0,1,0,0,1,1,1,0,1,1,0,1,1,0,1,0; match_vec=16'h5B72, match_cnt=9, done 18 cycles after start.
//  3. Pass-through, data_in=16'hFFFF -> match_cnt=16 (5'b10000, no wrap); 16'h0000 -> match_cnt=0.
//  4. Second start pulsed during SHIFT and on DONE cycle -> ignored, single done; start held
//     high 40 cycles -> done pulses exactly 19 cycles apart.
//  5. reset=0 at 8th SHIFT cycle -> outputs 0 immediately, no done; next start runs full 16 bits.
//  6. Real detector model, data_in=16'b0101101101110010 -> match_vec bit-for-bit equal to the
//     model's out stream with detector cleared at CLEAR; match_cnt equals popcount(match_vec).

Source files
------------

// File: rtl/seq_feed_pkg.sv
// Shared definitions for the detector feed sequencer: state encoding,
// default word width and the match-count width derivation.
package seq_feed_pkg;

  localparam int DEF_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Width needed to count from 0 up to and including w without wrapping.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_piso_reg.sv
// Parallel-in serial-out register: loads a word, then shifts it right one
// bit per enabled clock so that q0 walks through the word LSB first.
module seq_piso_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             q0
);

  logic [WIDTH-1:0] shreg;

  // Load takes priority over shift; otherwise the word is held.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shreg <= '0;
    end else if (load) begin
      shreg <= d;
    end else if (shift) begin
      shreg <= shreg >> 1;
    end
  end

  assign q0 = shreg[0];

endmodule

// File: rtl/seq_feed_ctrl.sv
// Sequencer that clears the bit-serial detector, feeds it a latched word
// LSB first, and records the detector's per-bit output as a match vector
// and a count of matches, finishing with a one-cycle done pulse.
module seq_feed_ctrl
  import seq_feed_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic             det_clr,
  output logic             det_value,
  input  logic             det_out,
  output logic [WIDTH-1:0] match_vec,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic             load;
  logic             shift;
  logic             q0;
  logic [IDX_W-1:0] idx;

  seq_piso_reg #(
    .WIDTH (WIDTH)
  ) u_piso (
    .clock (clock),
    .reset (reset),
    .load  (load),
    .shift (shift),
    .d     (data_in),
    .q0    (q0)
  );

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode plus the load/shift strobes for the serialiser.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = CLEAR;
        end
      end
      CLEAR: begin
        state_nxt = SHIFT;
      end
      SHIFT: begin
        shift = 1'b1;
        if (idx == LAST_IDX) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Status outputs are registered from the upcoming state so they line up with it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      det_clr <= 1'b0;
    end else begin
      busy    <= (state_nxt == CLEAR) || (state_nxt == SHIFT);
      done    <= (state_nxt == DONE);
      det_clr <= (state_nxt == CLEAR);
    end
  end

  // Capture the detector response for each fed bit; results hold until the next accepted start.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      match_vec <= '0;
      match_cnt <= '0;
      idx       <= '0;
    end else if (load) begin
      match_vec <= '0;
      match_cnt <= '0;
      idx       <= '0;
    end else if (state == SHIFT) begin
      match_vec[idx] <= det_out;
      match_cnt      <= match_cnt + CNT_W'(det_out);
      idx            <= idx + 1'b1;
    end
  end

  assign det_value = (state == SHIFT) & q0;

endmodule

// File: tb/tb_seq_feed_ctrl.sv
// Testbench for seq_feed_ctrl: directed words are issued by a driver that
// pushes the expected result into a scoreboard; a monitor pops and compares
// on every done pulse. A stub detector is either pass-through or a small
// overlapping "101" Mealy detector.
module tb_seq_feed_ctrl;

  localparam int WIDTH = 16;
  localparam int CNT_W = 5;

  logic             clock = 1'b0;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] data_in;
  logic             busy;
  logic             done;
  logic             det_clr;
  logic             det_value;
  logic             det_out;
  logic [WIDTH-1:0] match_vec;
  logic [CNT_W-1:0] match_cnt;

  int vectors     = 0;
  int miscompares = 0;
  int cycle       = 0;
  int done_seen   = 0;

  logic       use_model = 1'b0;
  logic [1:0] det_st;
  logic       model_out;

  typedef struct {
    logic [WIDTH-1:0] vec;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] stream;
    int               done_edge;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  logic [WIDTH-1:0] obs_stream;
  int               obs_len = 0;
  int               clr_cnt = 0;

  seq_feed_ctrl dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .data_in   (data_in),
    .busy      (busy),
    .done      (done),
    .det_clr   (det_clr),
    .det_value (det_value),
    .det_out   (det_out),
    .match_vec (match_vec),
    .match_cnt (match_cnt)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cycle++;

  // Overlapping "101" detector: 0 = nothing, 1 = seen 1, 2 = seen 10.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      det_st <= 2'd0;
    end else if (det_clr) begin
      det_st <= 2'd0;
    end else begin
      case (det_st)
        2'd0:    det_st <= det_value ? 2'd1 : 2'd0;
        2'd1:    det_st <= det_value ? 2'd1 : 2'd2;
        default: det_st <= det_value ? 2'd1 : 2'd0;
      endcase
    end
  end

  assign model_out = (det_st == 2'd2) && det_value;
  assign det_out   = use_model ? model_out : det_value;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: records the fed bit stream and compares against the scoreboard on done.
  always @(negedge clock or negedge reset) begin
    if (!reset) begin
      obs_len = 0;
      clr_cnt = 0;
    end else begin
      if (det_clr) begin
        clr_cnt++;
        obs_len = 0;
        check_output("det_value_in_clear", {31'd0, det_value}, 32'd0);
      end else if (busy) begin
        if (obs_len < WIDTH) obs_stream[obs_len] = det_value;
        obs_len++;
      end
      if (done) begin
        done_seen++;
        if (sb.size() == 0) begin
          check_output("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check_output("match_vec", {16'd0, match_vec}, {16'd0, e.vec});
          check_output("match_cnt", {27'd0, match_cnt}, {27'd0, e.cnt});
          check_output("det_value_stream", {16'd0, obs_stream}, {16'd0, e.stream});
          check_output("stream_len", obs_len, WIDTH);
          check_output("done_edge", cycle, e.done_edge);
          check_output("det_clr_pulses", clr_cnt, 32'd1);
          check_output("busy_at_done", {31'd0, busy}, 32'd0);
        end
        clr_cnt = 0;
        obs_len = 0;
      end
    end
  end

  // Issue one word from idle; optionally expect a completed result.
  task automatic apply_stimulus(input logic [WIDTH-1:0] word, input logic [WIDTH-1:0] exp_vec,
                                input logic [CNT_W-1:0] exp_cnt, input bit expect_done,
                                output int accept_edge);
    exp_t x;
    @(negedge clock);
    data_in = word;
    start   = 1'b1;
    accept_edge = cycle + 1;
    if (expect_done) begin
      x.vec       = exp_vec;
      x.cnt       = exp_cnt;
      x.stream    = word;
      x.done_edge = accept_edge + WIDTH + 1;
      sb.push_back(x);
    end
    @(negedge clock);
    start   = 1'b0;
    data_in = ~word;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (sb.size() == 0 && !busy && !done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      check_output("idle_timeout", 32'd0, 32'd1);
      sb.delete();
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_busy"},      {31'd0, busy},      32'd0);
    check_output({tag, "_done"},      {31'd0, done},      32'd0);
    check_output({tag, "_det_clr"},   {31'd0, det_clr},   32'd0);
    check_output({tag, "_det_value"}, {31'd0, det_value}, 32'd0);
    check_output({tag, "_match_vec"}, {16'd0, match_vec}, 32'd0);
    check_output({tag, "_match_cnt"}, {27'd0, match_cnt}, 32'd0);
  endtask

  initial begin
    int acc;
    int base;
    int seen_before;
    bit got_done;

    reset   = 1'b0;
    start   = 1'b1;
    data_in = 16'hFFFF;

    // Reset held with start high: everything idle and zero.
    #2;
    check_all_zero("reset");
    repeat (2) @(negedge clock);
    check_all_zero("reset_held");
    start = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    repeat (4) @(negedge clock);
    check_output("idle_no_start_busy", {31'd0, busy}, 32'd0);
    check_output("idle_no_start_done_count", done_seen, 32'd0);

    // Pass-through detector, directed words.
    apply_stimulus(16'b0101101101110010, 16'h5B72, 5'd9, 1'b1, acc);
    wait_idle();
    apply_stimulus(16'hFFFF, 16'hFFFF, 5'd16, 1'b1, acc);
    wait_idle();
    apply_stimulus(16'h0000, 16'h0000, 5'd0, 1'b1, acc);
    wait_idle();

    // Start pulses mid-SHIFT and on the DONE cycle are ignored.
    apply_stimulus(16'hA5C3, 16'hA5C3, 5'd8, 1'b1, acc);
    repeat (5) @(negedge clock);
    start   = 1'b1;
    data_in = 16'h1234;
    @(negedge clock);
    start   = 1'b0;
    got_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (done) begin
        got_done = 1'b1;
        break;
      end
    end
    check_output("done_after_midword_start", {31'd0, got_done}, 32'd1);
    start   = 1'b1;
    data_in = 16'hFFFF;
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    check_output("no_accept_from_done_cycle", {31'd0, busy}, 32'd0);
    wait_idle();

    // Start held for 40 cycles: accepts 19 cycles apart, three words.
    @(negedge clock);
    data_in = 16'h3C96;
    start   = 1'b1;
    base    = cycle + 1;
    for (int w = 0; w < 3; w++) begin
      e.vec       = 16'h3C96;
      e.cnt       = 5'd8;
      e.stream    = 16'h3C96;
      e.done_edge = base + 19 * w + WIDTH + 1;
      sb.push_back(e);
    end
    repeat (40) @(negedge clock);
    start = 1'b0;
    wait_idle();

    // Reset during the 8th SHIFT cycle aborts the word with no done.
    apply_stimulus(16'hBEEF, 16'h0000, 5'd0, 1'b0, acc);
    for (int i = 0; i < 40 && cycle < acc + 8; i++) @(negedge clock);
    #1;
    reset = 1'b0;
    #1;
    check_all_zero("midword_reset");
    seen_before = done_seen;
    @(negedge clock);
    reset = 1'b1;
    repeat (25) @(negedge clock);
    check_output("no_done_after_abort", done_seen, seen_before);
    apply_stimulus(16'hBEEF, 16'hBEEF, 5'd13, 1'b1, acc);
    wait_idle();

    // Real detector model: matches at bits 8, 11, 14.
    use_model = 1'b1;
    apply_stimulus(16'b0101101101110010, 16'h4900, 5'd3, 1'b1, acc);
    wait_idle();
    use_model = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
